// File: rtl/aes128_job_ctrl.sv
// AES-128 job sequencer: streams source lines through the AES core, writes the
// results to the destination buffer, then posts a completion line to the DSM.
module aes128_job_ctrl #(
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned TAG_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       hc_control,
    input  logic [ADDR_W-1:0] hc_dsm_base,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       src_size,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [TAG_W-1:0]  rd_req_tag,
    input  logic              rd_almfull,
    input  logic              rd_rsp_valid,
    input  logic [TAG_W-1:0]  rd_rsp_tag,
    input  logic [511:0]      rd_rsp_data,
    output logic              aes_in_valid,
    input  logic              aes_in_ready,
    output logic [TAG_W-1:0]  aes_in_tag,
    output logic [511:0]      aes_in_data,
    input  logic              aes_out_valid,
    output logic              aes_out_ready,
    input  logic [TAG_W-1:0]  aes_out_tag,
    input  logic [511:0]      aes_out_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [511:0]      wr_req_data,
    input  logic              wr_almfull,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned CNT_W   = TAG_W + 1;
    localparam int unsigned PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CRED_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = TAG_W + DATA_W;
    localparam logic [31:0]       MAX_LINES = 32'(1) << TAG_W;
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DSM_WR,
        S_DSM_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                hc_one_q, hc_one_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   dsm_q, dsm_d;
    logic [CNT_W-1:0]    nlines_q, nlines_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    wr_rsp_cnt_q, wr_rsp_cnt_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic [CRED_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_W-1:0]   rd_req_addr_q, rd_req_addr_d;
    logic [TAG_W-1:0]    rd_req_tag_q, rd_req_tag_d;
    logic                wr_req_valid_q, wr_req_valid_d;
    logic [ADDR_W-1:0]   wr_req_addr_q, wr_req_addr_d;
    logic [DATA_W-1:0]   wr_req_data_q, wr_req_data_d;
    logic [ENTRY_W-1:0]  fifo_mem_q [MAX_OUTSTANDING];

    logic                start_c;
    logic                in_run_c;
    logic                push_c;
    logic                pop_c;
    logic                issue_c;
    logic                wr_acc_c;
    logic [31:0]         nlines_raw_c;
    logic [CNT_W-1:0]    nlines_sat_c;
    logic [DATA_W-1:0]   dsm_data_c;

    // Handshake strobes shared by the FSM and datapath
    assign hc_one_d  = (hc_control == 32'h1);
    assign start_c   = hc_one_d && !hc_one_q;
    assign in_run_c  = (state_q == S_RUN);
    assign push_c    = rd_rsp_valid && in_run_c;
    assign pop_c     = (count_q != '0) && aes_in_ready;
    assign issue_c   = in_run_c && (rd_idx_q < nlines_q) && (credits_q != '0) && !rd_almfull;
    assign wr_acc_c  = aes_out_valid && aes_out_ready;

    assign aes_out_ready = !wr_almfull && in_run_c;
    assign aes_in_valid  = (count_q != '0);
    assign {aes_in_tag, aes_in_data} = fifo_mem_q[rd_ptr_q];

    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_tag   = rd_req_tag_q;
    assign wr_req_valid = wr_req_valid_q;
    assign wr_req_addr  = wr_req_addr_q;
    assign wr_req_data  = wr_req_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Line count (rounded up, saturated to the tag range) and DSM completion payload
    always_comb begin
        nlines_raw_c = 32'(src_size[31:6]) + 32'(|src_size[5:0]);
        nlines_sat_c = (nlines_raw_c > MAX_LINES) ? CNT_W'(MAX_LINES) : CNT_W'(nlines_raw_c);
        dsm_data_c          = '0;
        dsm_data_c[0]       = 1'b1;
        dsm_data_c[63:32]   = 32'(nlines_q);
    end

    // Next-state: job FSM, read credits, reorder FIFO pointers, request pulses
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        dsm_d          = dsm_q;
        nlines_d       = nlines_q;
        rd_idx_d       = rd_idx_q;
        wr_cnt_d       = wr_cnt_q;
        wr_rsp_cnt_d   = wr_rsp_cnt_q;
        busy_d         = busy_q;
        done_d         = done_q;
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_tag_d   = rd_req_tag_q;
        wr_req_valid_d = 1'b0;
        wr_req_addr_d  = wr_req_addr_q;
        wr_req_data_d  = wr_req_data_q;
        wr_ptr_d       = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d       = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d        = count_q + CRED_W'(push_c) - CRED_W'(pop_c);
        credits_d      = credits_q - CRED_W'(issue_c) + CRED_W'(pop_c);

        if (issue_c) begin
            rd_req_valid_d = 1'b1;
            rd_req_addr_d  = src_q + ADDR_W'(rd_idx_q);
            rd_req_tag_d   = rd_idx_q[TAG_W-1:0];
            rd_idx_d       = rd_idx_q + CNT_W'(1);
        end

        if (wr_acc_c) begin
            wr_req_valid_d = 1'b1;
            wr_req_addr_d  = dst_q + ADDR_W'(aes_out_tag);
            wr_req_data_d  = aes_out_data;
            wr_cnt_d       = wr_cnt_q + CNT_W'(1);
        end

        if (wr_rsp_valid && (state_q != S_IDLE)) begin
            wr_rsp_cnt_d = wr_rsp_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_c) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    dsm_d        = hc_dsm_base;
                    nlines_d     = nlines_sat_c;
                    rd_idx_d     = '0;
                    wr_cnt_d     = '0;
                    wr_rsp_cnt_d = '0;
                    credits_d    = CRED_MAX;
                    count_d      = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = (nlines_sat_c == '0) ? S_DSM_WR : S_RUN;
                end
            end
            S_RUN: begin
                if ((wr_cnt_q == nlines_q) && (wr_rsp_cnt_q == nlines_q)) begin
                    state_d = S_DSM_WR;
                end
            end
            S_DSM_WR: begin
                if (!wr_almfull) begin
                    wr_req_valid_d = 1'b1;
                    wr_req_addr_d  = dsm_q;
                    wr_req_data_d  = dsm_data_c;
                    state_d        = S_DSM_WAIT;
                end
            end
            S_DSM_WAIT: begin
                if (wr_rsp_valid) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any job in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            hc_one_q       <= 1'b0;
            src_q          <= '0;
            dst_q          <= '0;
            dsm_q          <= '0;
            nlines_q       <= '0;
            rd_idx_q       <= '0;
            wr_cnt_q       <= '0;
            wr_rsp_cnt_q   <= '0;
            credits_q      <= CRED_MAX;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_tag_q   <= '0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            hc_one_q       <= hc_one_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            dsm_q          <= dsm_d;
            nlines_q       <= nlines_d;
            rd_idx_q       <= rd_idx_d;
            wr_cnt_q       <= wr_cnt_d;
            wr_rsp_cnt_q   <= wr_rsp_cnt_d;
            credits_q      <= credits_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_tag_q   <= rd_req_tag_d;
            wr_req_valid_q <= wr_req_valid_d;
            wr_req_addr_q  <= wr_req_addr_d;
            wr_req_data_q  <= wr_req_data_d;
        end
    end

    // Read-return buffer storage; occupancy is tracked by the pointers above
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= {rd_rsp_tag, rd_rsp_data};
        end
    end

    // Read credits bound the buffer, so a push into a full buffer is a design error
    assert property (@(posedge clk) disable iff (!reset)
                     !(push_c && !pop_c && (count_q == CRED_MAX)));

endmodule

// File: tb/tb_aes128_job_ctrl.sv
// Bench for aes128_job_ctrl: random memory/AES/write-channel responders and a
// per-job reference model of which lines must be read and written where.
module tb_aes128_job_ctrl;

    localparam int MAXO = 16;

    logic         clk;
    logic         reset;
    logic [31:0]  hc_control;
    logic [41:0]  hc_dsm_base, src_addr, dst_addr;
    logic [31:0]  src_size;
    logic         rd_req_valid;
    logic [41:0]  rd_req_addr;
    logic [15:0]  rd_req_tag;
    logic         rd_almfull, rd_rsp_valid;
    logic [15:0]  rd_rsp_tag;
    logic [511:0] rd_rsp_data;
    logic         aes_in_valid, aes_in_ready;
    logic [15:0]  aes_in_tag;
    logic [511:0] aes_in_data;
    logic         aes_out_valid, aes_out_ready;
    logic [15:0]  aes_out_tag;
    logic [511:0] aes_out_data;
    logic         wr_req_valid;
    logic [41:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic         wr_almfull, wr_rsp_valid;
    logic         busy, done;

    aes128_job_ctrl dut (
        .clk(clk), .reset(reset), .hc_control(hc_control), .hc_dsm_base(hc_dsm_base),
        .src_addr(src_addr), .src_size(src_size), .dst_addr(dst_addr),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag),
        .rd_rsp_data(rd_rsp_data), .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready),
        .aes_in_tag(aes_in_tag), .aes_in_data(aes_in_data), .aes_out_valid(aes_out_valid),
        .aes_out_ready(aes_out_ready), .aes_out_tag(aes_out_tag), .aes_out_data(aes_out_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    // Knobs and job addresses, written only by the main sequence
    int          rd_order = 0;     // 0 in order, 1 reverse (LIFO), 2 random
    int          ready_mode = 2;   // 0 held low, 1 random, 2 always high
    int          walm_mode = 0;    // 0 off, 1 toggle every 3 cycles
    int          ralm_mode = 0;    // 0 off, 1 random
    int          clear_gen = 0;
    int          stale_gen = 0;
    logic [41:0] cur_src = '0, cur_dst = '0, cur_dsm = '0;

    // Observations, written only by the responder process
    int           env_clear_gen = 0, env_stale_gen = 0;
    int           rd_issued, rd_addr_err, rd_stray, wr_total, wr_stray, alm_viol;
    int           dsm_cnt, wr_pend_rsp, inflight, max_inflight, walm_ctr;
    int           rd_cnt [256];
    int           wr_cnt [256];
    logic [511:0] wr_dat [256];
    logic [511:0] dsm_data;
    logic         rd_alm_prev, wr_alm_prev;
    int           rd_pend [$];
    logic [15:0]  aes_tq [$];
    logic [511:0] aes_dq [$];

    function automatic logic [511:0] line_data(input logic [41:0] a);
        logic [511:0] r;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            w = (a[31:0] ^ {22'h0, a[41:32]}) + 32'(i) * 32'h0100_0193;
            w = (w * 32'h9E37_79B1) ^ 32'(i);
            r[i*32 +: 32] = w;
        end
        return r;
    endfunction

    function automatic logic [511:0] aes_fn(input logic [511:0] d);
        return d ^ {16{32'hA5C3_0F1E}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    // Responders: memory reads, AES core, write channel; drive at negedge, predict handshakes at +1
    initial begin : env
        int idx;
        logic [41:0] off;
        rd_almfull = 0; rd_rsp_valid = 0; rd_rsp_tag = '0; rd_rsp_data = '0;
        aes_in_ready = 0; aes_out_valid = 0; aes_out_tag = '0; aes_out_data = '0;
        wr_almfull = 0; wr_rsp_valid = 0; rd_alm_prev = 0; wr_alm_prev = 0;
        walm_ctr = 0; dsm_data = '0;
        forever begin
            @(negedge clk);
            if (clear_gen != env_clear_gen) begin
                env_clear_gen = clear_gen;
                rd_issued = 0; rd_addr_err = 0; rd_stray = 0; wr_total = 0; wr_stray = 0;
                alm_viol = 0; dsm_cnt = 0; wr_pend_rsp = 0; inflight = 0; max_inflight = 0;
                dsm_data = '0;
                for (int t = 0; t < 256; t++) begin
                    rd_cnt[t] = 0; wr_cnt[t] = 0; wr_dat[t] = '0;
                end
                rd_pend.delete(); aes_tq.delete(); aes_dq.delete();
            end
            if (rd_req_valid === 1'b1) begin
                rd_issued++;
                if (rd_alm_prev) alm_viol++;
                if (rd_req_addr !== cur_src + 42'(rd_req_tag)) rd_addr_err++;
                if (rd_req_tag < 16'd256) rd_cnt[rd_req_tag[7:0]]++;
                else rd_stray++;
                rd_pend.push_back(int'(rd_req_tag));
                inflight++;
                if (inflight > max_inflight) max_inflight = inflight;
            end
            if (wr_req_valid === 1'b1) begin
                if (wr_alm_prev) alm_viol++;
                wr_pend_rsp++;
                if (wr_req_addr === cur_dsm) begin
                    dsm_cnt++;
                    dsm_data = wr_req_data;
                end else begin
                    off = wr_req_addr - cur_dst;
                    wr_total++;
                    if (off < 42'd256) begin
                        wr_cnt[off[7:0]]++;
                        wr_dat[off[7:0]] = wr_req_data;
                    end else wr_stray++;
                end
            end
            if (!reset) begin
                rd_almfull = 0; rd_rsp_valid = 0; aes_in_ready = 0; aes_out_valid = 0;
                wr_almfull = 0; wr_rsp_valid = 0; walm_ctr = 0;
            end else begin
                rd_almfull = (ralm_mode == 1) && ($urandom_range(0, 3) == 0);
                walm_ctr++;
                if (walm_mode == 1) begin
                    if (walm_ctr >= 3) begin
                        walm_ctr = 0;
                        wr_almfull = ~wr_almfull;
                    end
                end else wr_almfull = 0;
                rd_rsp_valid = 0;
                if (rd_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                    if (rd_order == 0) idx = 0;
                    else if (rd_order == 1) idx = rd_pend.size() - 1;
                    else idx = int'($urandom_range(0, rd_pend.size() - 1));
                    rd_rsp_valid = 1;
                    rd_rsp_tag = 16'(rd_pend[idx]);
                    rd_rsp_data = line_data(cur_src + 42'(rd_pend[idx]));
                    rd_pend.delete(idx);
                end
                aes_in_ready = (ready_mode == 2) || ((ready_mode == 1) && ($urandom_range(0, 1) == 1));
                aes_out_valid = 0;
                if (aes_tq.size() != 0 && $urandom_range(0, 3) != 0) begin
                    aes_out_valid = 1;
                    aes_out_tag = aes_tq[0];
                    aes_out_data = aes_fn(aes_dq[0]);
                end
                wr_rsp_valid = 0;
                if (wr_pend_rsp > 0 && $urandom_range(0, 1) == 1) begin
                    wr_rsp_valid = 1;
                    wr_pend_rsp--;
                end
                if (stale_gen != env_stale_gen) begin
                    env_stale_gen = stale_gen;
                    rd_rsp_valid = 1; rd_rsp_tag = '0; rd_rsp_data = line_data('0);
                    wr_rsp_valid = 1;
                end
            end
            rd_alm_prev = rd_almfull;
            wr_alm_prev = wr_almfull;
            #1;
            if (reset) begin
                if (aes_in_valid === 1'b1 && aes_in_ready) begin
                    aes_tq.push_back(aes_in_tag);
                    aes_dq.push_back(aes_in_data);
                    inflight--;
                end
                if (aes_out_valid && aes_out_ready === 1'b1) begin
                    if (wr_almfull) alm_viol++;
                    void'(aes_tq.pop_front());
                    void'(aes_dq.pop_front());
                end
            end
        end
    end

    task automatic new_addrs();
        cur_src = {10'($urandom), $urandom};
        cur_dst = {10'($urandom), $urandom};
        cur_dsm = cur_dst + 42'h1_0000;
        clear_gen++;
    endtask

    task automatic start_job(input string name, input int size);
        tick();
        src_addr = cur_src; dst_addr = cur_dst; hc_dsm_base = cur_dsm;
        src_size = 32'(size); hc_control = 32'h0;
        tick();
        hc_control = 32'h1;
        tick();
        chk({name, "_busy_at_start"}, 512'(busy), 512'(1));
        chk({name, "_done_cleared"}, 512'(done), 512'(0));
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done_in_budget"}, 512'(done), 512'(1));
    endtask

    task automatic check_job(input string name, input int n);
        int rd_bad = 0, wr_bad = 0;
        logic [511:0] exp_dsm;
        for (int t = 0; t < 256; t++) begin
            if (rd_cnt[t] != ((t < n) ? 1 : 0)) rd_bad++;
            if (wr_cnt[t] != ((t < n) ? 1 : 0)) wr_bad++;
        end
        chk({name, "_busy_end"}, 512'(busy), 512'(0));
        chk({name, "_reads"}, 512'(rd_issued), 512'(n));
        chk({name, "_read_tags_once"}, 512'(rd_bad + rd_stray), 512'(0));
        chk({name, "_read_addr"}, 512'(rd_addr_err), 512'(0));
        chk({name, "_write_lines_once"}, 512'(wr_bad + wr_stray), 512'(0));
        chk({name, "_almfull_respected"}, 512'(alm_viol), 512'(0));
        chk({name, "_inflight_bound"}, 512'(max_inflight <= MAXO), 512'(1));
        for (int t = 0; t < n; t++)
            chk({name, "_wdata"}, wr_dat[t], aes_fn(line_data(cur_src + 42'(t))));
        exp_dsm = '0;
        exp_dsm[0] = 1'b1;
        exp_dsm[63:32] = 32'(n);
        chk({name, "_dsm_count"}, 512'(dsm_cnt), 512'(1));
        chk({name, "_dsm_data"}, dsm_data, exp_dsm);
    endtask

    task automatic run_job(input string name, input int size, input int budget);
        new_addrs();
        start_job(name, size);
        wait_done(name, budget);
        check_job(name, (size + 63) / 64);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_rd_req_valid"}, 512'(rd_req_valid), 512'(0));
        chk({name, "_aes_in_valid"}, 512'(aes_in_valid), 512'(0));
        chk({name, "_wr_req_valid"}, 512'(wr_req_valid), 512'(0));
        chk({name, "_aes_out_ready"}, 512'(aes_out_ready), 512'(0));
        chk({name, "_busy"}, 512'(busy), 512'(0));
        chk({name, "_done"}, 512'(done), 512'(0));
    endtask

    initial begin : main
        int n;
        reset = 1'b0; hc_control = '0; hc_dsm_base = '0; src_addr = '0;
        dst_addr = '0; src_size = '0;
        repeat (3) tick();
        #1 check_quiet("reset");
        tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", 512'(busy), 512'(0));

        // 4 lines, in-order, AES always ready
        rd_order = 0; ready_mode = 2; walm_mode = 0; ralm_mode = 0;
        run_job("four_lines", 256, 2000);
        run_job("partial_line", 100, 2000);
        run_job("empty_job", 0, 2000);

        // 64 lines with AES stalled: credits must cap reads at MAX_OUTSTANDING
        ready_mode = 0; rd_order = 2;
        new_addrs();
        start_job("stall", 64 * 64);
        repeat (200) tick();
        chk("stall_reads_capped", 512'(rd_issued), 512'(MAXO));
        chk("stall_inflight_full", 512'(max_inflight), 512'(MAXO));
        ready_mode = 1;
        wait_done("stall", 5000);
        check_job("stall", 64);

        // Reverse-order returns with write almfull toggling every 3 cycles
        rd_order = 1; walm_mode = 1; ralm_mode = 1; ready_mode = 1;
        run_job("reverse_almfull", int'($urandom_range(1, 48 * 64)), 8000);

        // Holding START at 1 must not launch another job
        clear_gen++;
        repeat (3) begin
            tick();
            hc_control = 32'h1;
        end
        repeat (20) tick();
        chk("hold_busy", 512'(busy), 512'(0));
        chk("hold_done", 512'(done), 512'(1));
        chk("hold_no_reads", 512'(rd_issued), 512'(0));
        chk("hold_no_dsm", 512'(dsm_cnt), 512'(0));
        rd_order = 2; walm_mode = 0; ralm_mode = 0;
        run_job("restart", 7 * 64 + 5, 4000);

        // Reset in the middle of a 10-line job
        ready_mode = 2;
        new_addrs();
        start_job("mid_reset", 640);
        n = 0;
        while (wr_total < 5 && n < 2000) begin
            tick();
            n++;
        end
        chk("mid_reset_progress", 512'(wr_total >= 5), 512'(1));
        reset = 1'b0;
        hc_control = 32'h0;
        clear_gen++;
        #1 check_quiet("in_reset");
        repeat (2) tick();
        reset = 1'b1;
        stale_gen++;
        repeat (4) tick();
        chk("stale_aes_in_valid", 512'(aes_in_valid), 512'(0));
        chk("stale_busy", 512'(busy), 512'(0));
        chk("stale_no_writes", 512'(wr_total + dsm_cnt), 512'(0));
        run_job("after_reset", 640, 3000);

        // A few fully random jobs
        for (int j = 0; j < 3; j++) begin
            rd_order = int'($urandom_range(0, 2));
            ready_mode = int'($urandom_range(1, 2));
            walm_mode = int'($urandom_range(0, 1));
            ralm_mode = int'($urandom_range(0, 1));
            run_job("random", int'($urandom_range(0, 40 * 64)), 8000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes128_job_ctrl.md
Name: aes128_job_ctrl

Overview:
- Job sequencer directly downstream of the CSR block. Consumes hc_control, hc_dsm_base and the two buffer descriptors (buffer 0 = source, buffer 1 = destination).
- Per job: streams source cache lines through the AES core, writes the results to the destination, then posts a completion line to the DSM.
- Sits between the CSR block, the AES core stream interface and the CCI-P c0/c1 request and response channels. The channels are exposed here as flattened valid/data signals; the wrapper packs them into CCI-P headers.

Parameters:
- ADDR_W, 42, cache-line address width (byte address >> 6).
- MAX_OUTSTANDING, 16, maximum read lines in flight plus lines buffered; power of 2, ≤ 256.
- TAG_W, 16, mdata/tag width; line index within the job.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- hc_control  in  32  control word; value 32'h1 = START
- hc_dsm_base  in  ADDR_W  DSM line address
- src_addr  in  ADDR_W  source buffer line address
- src_size  in  32  job size in bytes
- dst_addr  in  ADDR_W  destination buffer line address
- rd_req_valid  out  1  read request
- rd_req_addr  out  ADDR_W  read line address
- rd_req_tag  out  TAG_W  line index
- rd_almfull  in  1  c0TxAlmFull
- rd_rsp_valid  in  1  read response; cannot be back-pressured
- rd_rsp_tag  in  TAG_W  returned index; any order
- rd_rsp_data  in  512  line data
- aes_in_valid  out  1  line to AES core
- aes_in_ready  in  1  AES core accept
- aes_in_tag  out  TAG_W  line index
- aes_in_data  out  512  plaintext line
- aes_out_valid  in  1  result from AES core
- aes_out_ready  out  1  result accept
- aes_out_tag  in  TAG_W  line index
- aes_out_data  in  512  ciphertext line
- wr_req_valid  out  1  write request
- wr_req_addr  out  ADDR_W  write line address
- wr_req_data  out  512  write data
- wr_almfull  in  1  c1TxAlmFull
- wr_rsp_valid  in  1  write response, one per request
- busy  out  1  job in progress
- done  out  1  last job completed; cleared on next start

Behaviour:
- Reset (reset==0, async): state IDLE; all counters 0; rd_req_valid, aes_in_valid, wr_req_valid, busy, done all 0; aes_out_ready 0; FIFO empty.
- Start detection:
  - Register hc_control each cycle; start = (hc_control==1) && (prev!=1).
  - Start is honoured only in IDLE or DONE; ignored otherwise.
- On start:
  - Latch src_addr, dst_addr, hc_dsm_base.
  - Compute nlines = src_size[31:6] + |src_size[5:0]; nlines is saturated to 2^TAG_W.
  - done←0, busy←1.
  - Go to RUN, or to DSM_WR if nlines==0.
- RUN, read issue:
  - rd_req_valid=1 when rd_idx<nlines && credits>0 && !rd_almfull.
  - rd_req_addr=src+rd_idx, rd_req_tag=rd_idx.
  - Each issue: rd_idx++, credits--. Credits reset to MAX_OUTSTANDING.
- Read data:
  - Each rd_rsp_valid pushes {tag,data} into a MAX_OUTSTANDING-deep FIFO. Credits guarantee no overflow; an overflow is an assertion failure.
  - FIFO head drives aes_in_*. A pop on aes_in_valid&&aes_in_ready returns one credit.
  - A same-cycle issue and return nets to 0.
- Write path:
  - aes_out_ready = !wr_almfull && state==RUN.
  - On aes_out_valid&&aes_out_ready: one-cycle registered write, wr_req_addr=dst+aes_out_tag, data=aes_out_data; wr_cnt++.
  - Order is irrelevant; the tag fixes the address.
- Write responses: wr_rsp_cnt++ per wr_rsp_valid in any state except IDLE.
- RUN→DSM_WR when wr_cnt==nlines && wr_rsp_cnt==nlines.
- DSM_WR: when !wr_almfull, issue one write to the latched DSM address. Data bit0=1, bits[63:32]=nlines, rest 0. Then go to DSM_WAIT.
- DSM_WAIT: on wr_rsp_valid → DONE; done←1, busy←0.
- DONE: holds until the next start edge.
- Request valids are single-cycle pulses per request; there is no ready on the request channels, only almfull gating.
- Reset mid-job: all state is discarded immediately. Responses arriving after reset deasserts are ignored while in IDLE.

Test Plan:
- src_size=256 (4 lines), in-order responses, AES passthrough → 4 reads tags 0..3, 4 writes at dst+0..3 with matching data, DSM write bit0=1 and [63:32]=4, done=1.
- src_size=100 → nlines=2; src_size=0 → no reads, immediate DSM write with [63:32]=0, done=1.
- 64 lines, MAX_OUTSTANDING=16, aes_in_ready held 0 → exactly 16 reads issued, then stall. Release ready → all 64 complete; FIFO never overflows.
- Responses returned in reverse tag order, and wr_almfull toggled every 3 cycles → every line written to dst+tag exactly once; no write issued while almfull=1.
- Write hc_control=1 twice without an intermediate change → one job only. Write 0 then 1 after done → second job runs, done drops at its start.
- Assert reset mid-RUN after 5 of 10 lines → outputs 0 within the reset assertion. A subsequent start runs the full job correctly.
